// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data port.
// Optional fetch anti-starvation: define MEMARB_ANTISTARVE_EN.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [2:0]    m_size,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          grant_d
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          state_q;
    logic            m_req_q;
    logic            m_we_q;
    logic [2:0]      m_size_q;
    logic [AW-1:0]   m_addr_q;
    logic [DW-1:0]   m_wdata_q;
    logic            grant_d_q;

    logic force_if;
    logic pick_d;
    logic pick_i;

    assign pick_d = d_req && !force_if;
    assign pick_i = !pick_d && if_req;

`ifdef MEMARB_ANTISTARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;

    assign force_if = if_req && (starve_q == LIMIT);

    // Counts data wins over a waiting fetch; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (pick_d) begin
                if (!if_req)
                    starve_d = '0;
                else if (starve_q != LIMIT)
                    starve_d = starve_q + 1'b1;
            end else if (pick_i) begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = ^STARVE_LIMIT;
    assign force_if = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_size_q  <= 3'b000;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            grant_d_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        m_req_q   <= 1'b1;
                        m_we_q    <= d_we;
                        m_size_q  <= d_size;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                        grant_d_q <= 1'b1;
                        state_q   <= BUSY_D;
                    end else if (pick_i) begin
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_size_q  <= 3'b010;
                        m_addr_q  <= if_addr;
                        m_wdata_q <= '0;
                        grant_d_q <= 1'b0;
                        state_q   <= BUSY_I;
                    end else begin
                        m_req_q   <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (m_ack) begin
                        m_req_q   <= 1'b0;
                        grant_d_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    m_req_q   <= 1'b0;
                    grant_d_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_size   = m_size_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign grant_d  = grant_d_q;

    assign if_ready = m_ack && (state_q == BUSY_I);
    assign d_ready  = m_ack && (state_q == BUSY_D);
    assign if_rdata = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table plus a ready/rdata scoreboard.
// Hand sequences cover reset abort and arbitration fairness.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [2:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        grant_d;

    mem_port_arbiter #(
        .AW(32),
        .DW(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_rdata(if_rdata),
        .if_ready(if_ready),
        .d_req(d_req),
        .d_we(d_we),
        .d_size(d_size),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_ready(d_ready),
        .m_req(m_req),
        .m_we(m_we),
        .m_size(m_size),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_ack(m_ack),
        .m_rdata(m_rdata),
        .grant_d(grant_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        port_d;
        logic [31:0] rdata;
    } sb_t;

    sb_t sbq[$];

    // Every ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (if_ready || d_ready) begin
            sb_t e;
            chk("sb_one_ready", 32'(if_ready && d_ready), 32'd0);
            if (sbq.size() == 0) begin
                chk("sb_unexpected_ready", 32'(1), 32'(0));
            end else begin
                e = sbq.pop_front();
                chk("sb_port", 32'(d_ready), 32'(e.port_d));
                chk("sb_rdata", d_ready ? d_rdata : if_rdata, e.rdata);
            end
        end
    end

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [2:0]  ds;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic        e_gnt;
        logic        e_we;
        logic [2:0]  e_sz;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_ir;
        logic        e_dr;
    } vec_t;

    function automatic vec_t mk(
        logic ir, logic [31:0] ia, logic dr, logic dwe, logic [2:0] ds,
        logic [31:0] da, logic [31:0] dwd, logic ack, logic [31:0] rd,
        logic e_req, logic e_gnt, logic e_we, logic [2:0] e_sz,
        logic [31:0] e_addr, logic [31:0] e_wd, logic e_ir, logic e_dr);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.ds = ds;
        v.da = da; v.dwd = dwd; v.ack = ack; v.rd = rd;
        v.e_req = e_req; v.e_gnt = e_gnt; v.e_we = e_we; v.e_sz = e_sz;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_ir = e_ir; v.e_dr = e_dr;
        return v;
    endfunction

    vec_t tbl[19];

    task automatic drive(input vec_t v);
        if_req  = v.ir;
        if_addr = v.ia;
        d_req   = v.dr;
        d_we    = v.dwe;
        d_size  = v.ds;
        d_addr  = v.da;
        d_wdata = v.dwd;
        m_ack   = v.ack;
        m_rdata = v.rd;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_size = 0; d_addr = 0; d_wdata = 0; m_ack = 0; m_rdata = 0;
    endtask

    initial begin
        bit exp_d;
        int g;

        // fetch hit on first cycle
        tbl[0]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h00500093,
                     1, 0, 0, 3'b010, 32'h100, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0);
        // simultaneous requests: data first, fetch after bubble
        tbl[3]  = mk(1, 32'h104, 1, 1, 3'b010, 32'h2000, 32'hDEADBEEF,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 32'h104, 1, 1, 3'b010, 32'h2000, 32'hDEADBEEF,
                     1, 32'h0, 1, 1, 1, 3'b010, 32'h2000, 32'hDEADBEEF,
                     0, 1);
        tbl[5]  = mk(1, 32'h104, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 32'h104, 0, 0, 0, 0, 0, 1, 32'h11111111,
                     1, 0, 0, 3'b010, 32'h104, 0, 1, 0);
        // stray ack in IDLE
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h5,
                     0, 0, 0, 0, 0, 0, 0, 0);
        // delayed ack, data inputs wander
        tbl[8]  = mk(0, 0, 1, 0, 3'b001, 32'h2000, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0, 3'b001, 32'h3000, 0, 0, 0,
                     1, 1, 0, 3'b001, 32'h2000, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 1, 3'b001, 32'h2000, 32'h77, 0, 0,
                     1, 1, 0, 3'b001, 32'h2000, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 0, 3'b001, 32'h4000, 0, 0, 0,
                     1, 1, 0, 3'b001, 32'h2000, 0, 0, 0);
        tbl[12] = mk(0, 0, 1, 0, 3'b001, 32'h4000, 0, 1, 32'hCAFEF00D,
                     1, 1, 0, 3'b001, 32'h2000, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0);
        // fetch withdrawn after grant
        tbl[14] = mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 0, 0, 3'b010, 32'h200, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 0, 0, 3'b010, 32'h200, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D,
                     1, 0, 0, 3'b010, 32'h200, 0, 1, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b0;
        idle_inputs();
        #3;
        chk("rst_m_req", 32'(m_req), 0);
        chk("rst_m_we", 32'(m_we), 0);
        chk("rst_m_size", 32'(m_size), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_grant_d", 32'(grant_d), 0);
        @(posedge clk); #2;
        reset = 1'b1;

        // reset while a data transaction is outstanding
        @(posedge clk); #2;
        d_req = 1; d_we = 1; d_size = 3'b010;
        d_addr = 32'h800; d_wdata = 32'h1234;
        @(posedge clk); #2;
        @(negedge clk);
        chk("t1_busy_m_req", 32'(m_req), 1);
        chk("t1_busy_grant", 32'(grant_d), 1);
        #1;
        reset = 1'b0;
        m_ack = 1;
        #1;
        chk("t1_abort_m_req", 32'(m_req), 0);
        chk("t1_abort_grant", 32'(grant_d), 0);
        chk("t1_abort_d_ready", 32'(d_ready), 0);
        @(posedge clk); #2;
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_post_m_req", 32'(m_req), 0);
            @(posedge clk); #2;
        end

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i]);
            if (tbl[i].e_ir || tbl[i].e_dr)
                sbq.push_back({tbl[i].e_dr, tbl[i].rd});
            @(negedge clk);
            chk($sformatf("v%0d_m_req", i), 32'(m_req), 32'(tbl[i].e_req));
            chk($sformatf("v%0d_grant", i), 32'(grant_d),
                32'(tbl[i].e_gnt));
            chk($sformatf("v%0d_if_ready", i), 32'(if_ready),
                32'(tbl[i].e_ir));
            chk($sformatf("v%0d_d_ready", i), 32'(d_ready),
                32'(tbl[i].e_dr));
            if (tbl[i].e_req) begin
                chk($sformatf("v%0d_m_we", i), 32'(m_we),
                    32'(tbl[i].e_we));
                chk($sformatf("v%0d_m_size", i), 32'(m_size),
                    32'(tbl[i].e_sz));
                chk($sformatf("v%0d_m_addr", i), m_addr, tbl[i].e_addr);
                chk($sformatf("v%0d_m_wdata", i), m_wdata, tbl[i].e_wd);
            end
            @(posedge clk); #2;
        end

        // continuous contention from a fresh reset
        idle_inputs();
        reset = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        d_req = 1; d_we = 0; d_size = 3'b010; d_addr = 32'h3000;
        if_req = 1; if_addr = 32'h400;
        g = 0;
        for (int c = 0; c < 200 && g < 15; c++) begin
            @(posedge clk); #2;
`ifdef MEMARB_ANTISTARVE_EN
            exp_d = (g % 5) != 4;
`else
            exp_d = 1'b1;
`endif
            if (m_req) begin
                m_ack = 1;
                m_rdata = $urandom;
                sbq.push_back({exp_d, m_rdata});
            end else begin
                m_ack = 0;
            end
            @(negedge clk);
            if (m_req) begin
                chk($sformatf("t6_grant%0d", g), 32'(grant_d), 32'(exp_d));
                g++;
            end
        end
        chk("t6_grant_count", g, 15);
        @(posedge clk); #2;
        idle_inputs();
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
